erasable_core_stack: RTL and testbench

- Cycle-level behavioural model of the erasable core memory array, 2048 words x 16 bits, directly downstream of the memory timing/addressing module.
- Consumes the one-hot XB/XT/YB selects, the erasable bank select, REX/REY/WEX/WEY drive strobes, the SBE sense strobe and the ZID inhibit control.
- Returns sensed data to the sense-amp/G-register path.
- Models core physics: read is destructive and write can only set bits. The timing module's rewrite sequence is therefore required for data retention.

---
 rtl/erasable_core_stack.sv | 184 ++++++++++++++++++
 tb/tb_erasable_core_stack.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/erasable_core_stack.sv
// Erasable core array model: destructive read into a sense buffer, OR-only writes, 2048 x WIDTH words.
// SA valid one edge after SBE; write lands one edge after entering WRITE; no backpressure, protocol slips raise sticky ERR.
module erasable_core_stack #(
  parameter int WIDTH     = 16,
  parameter int NBANK     = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic [7:0]       XB,
  input  logic [7:0]       XT,
  input  logic [3:0]       YB,
  input  logic [2:0]       EB,
  input  logic             REX,
  input  logic             REY,
  input  logic             WEX,
  input  logic             WEY,
  input  logic             SBE,
  input  logic             ZID,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] SA,
  output logic             SAV,
  output logic             ERR,
  output logic [1:0]       STATE
);

  localparam int DEPTH = 8 * 8 * 4 * NBANK;
  localparam int AW    = 11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_SENSED = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  function automatic logic [2:0] enc8(input logic [7:0] v);
    enc8 = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) enc8 = i[2:0];
    end
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] v);
    enc4 = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) enc4 = i[1:0];
    end
  endfunction

  // Core is nonvolatile: contents only ever change through the write port below, never by rst.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: (INIT_ZERO ? {WIDTH{1'b0}} : {WIDTH{1'bx}})};

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] sbuf_q, sbuf_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic             sav_q, sav_d;
  logic             err_q, err_d;

  logic             rd, wr, sel_ok;
  logic [AW-1:0]    cur_addr;
  logic [WIDTH-1:0] wdata;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdat;

  assign rd       = REX & REY;
  assign wr       = WEX & WEY;
  assign sel_ok   = $onehot(XB) & $onehot(XT) & $onehot(YB);
  assign cur_addr = {EB, enc8(XT), enc8(XB), enc4(YB)};
  assign wdata    = ZID ? '0 : WD;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sbuf_d    = sbuf_q;
    sa_d      = sa_q;
    sav_d     = sav_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdat  = '0;

    case (state_q)
      S_IDLE: begin
        if (rd || wr) begin
          if (!sel_ok) begin
            err_d = 1'b1;
          end else if (rd) begin
            // Read wins over a simultaneous write drive; the cell is cleared as it is sensed.
            if (wr) err_d = 1'b1;
            addr_d    = cur_addr;
            sbuf_d    = mem[cur_addr];
            mem_we    = 1'b1;
            mem_waddr = cur_addr;
            mem_wdat  = '0;
            state_d   = S_READ;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = cur_addr;
            mem_wdat  = mem[cur_addr] | wdata;
            err_d     = 1'b1;
          end
        end
      end

      S_READ: begin
        if (wr) err_d = 1'b1;
        if (SBE) begin
          sa_d    = sbuf_q;
          sav_d   = 1'b1;
          state_d = S_SENSED;
        end else if (!rd) begin
          err_d   = 1'b1;
          sav_d   = 1'b0;
          state_d = S_SENSED;
        end
      end

      S_SENSED: begin
        if (rd) begin
          // A second read before the rewrite drops the pending word.
          err_d = 1'b1;
          if (sel_ok) begin
            addr_d    = cur_addr;
            sbuf_d    = mem[cur_addr];
            mem_we    = 1'b1;
            mem_waddr = cur_addr;
            mem_wdat  = '0;
            sav_d     = 1'b0;
            state_d   = S_READ;
          end
        end else if (wr) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        // Latched address: selects are free to move once the read has completed.
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        mem_wdat  = mem[addr_q] | wdata;
        if (rd) err_d = 1'b1;
        if (!wr) begin
          sav_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sbuf_q  <= '0;
      sa_q    <= '0;
      sav_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sbuf_q  <= sbuf_d;
      sa_q    <= sa_d;
      sav_q   <= sav_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

  assign SA    = sa_q;
  assign SAV   = sav_q;
  assign ERR   = err_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_erasable_core_stack.sv
// Directed bench for erasable_core_stack; sensed words are checked by a SAV-driven scoreboard monitor.
module tb_erasable_core_stack;

  logic        CLOCK = 1'b0;
  logic        rst   = 1'b1;
  logic [7:0]  XB    = 8'h01;
  logic [7:0]  XT    = 8'h01;
  logic [3:0]  YB    = 4'h1;
  logic [2:0]  EB    = 3'd0;
  logic        REX   = 1'b0;
  logic        REY   = 1'b0;
  logic        WEX   = 1'b0;
  logic        WEY   = 1'b0;
  logic        SBE   = 1'b0;
  logic        ZID   = 1'b0;
  logic [15:0] WD    = 16'h0000;
  logic [15:0] SA;
  logic        SAV;
  logic        ERR;
  logic [1:0]  STATE;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic        prev_sav = 1'b0;

  erasable_core_stack #(.WIDTH(16), .NBANK(8), .INIT_ZERO(1'b1)) dut (
    .CLOCK(CLOCK), .rst(rst), .XB(XB), .XT(XT), .YB(YB), .EB(EB),
    .REX(REX), .REY(REY), .WEX(WEX), .WEY(WEY), .SBE(SBE), .ZID(ZID),
    .WD(WD), .SA(SA), .SAV(SAV), .ERR(ERR), .STATE(STATE)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // Monitor: every fresh SAV assertion must match the oldest expected sensed word.
  always @(negedge CLOCK) begin
    if (SAV && !prev_sav) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sa_unexpected: got SA=%h with no word expected", SA);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (SA !== e) begin
          n_fail++;
          $display("FAIL sa_word: got %h expected %h", SA, e);
        end
      end
    end
    prev_sav = SAV;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic sel(input int eb, input int xt, input int xb, input int yb);
    EB = 3'(eb);
    XT = 8'h01 << xt;
    XB = 8'h01 << xb;
    YB = 4'h1 << yb;
  endtask

  task automatic do_reset();
    REX = 0; REY = 0; WEX = 0; WEY = 0; SBE = 0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic write_no_read(input logic [15:0] data);
    WD = data; ZID = 1'b0;
    WEX = 1; WEY = 1;
    cyc();
    WEX = 0; WEY = 0;
    cyc();
  endtask

  // Cells start all-zero, so an IDLE write followed by rst preloads a word cleanly.
  task automatic preload(input int eb, input int xt, input int xb, input int yb, input logic [15:0] data);
    sel(eb, xt, xb, yb);
    write_no_read(data);
    do_reset();
  endtask

  // Full read / SBE / rewrite sequence; the sensed word goes to the scoreboard.
  task automatic rw_cycle(input logic [15:0] exp_sa, input logic zid, input logic [15:0] wd);
    REX = 1; REY = 1;
    cyc();
    REX = 0; REY = 0; SBE = 1;
    exp_q.push_back(exp_sa);
    cyc();
    SBE = 0;
    chk("sav_after_sbe", {15'd0, SAV}, 16'd1);
    chk("state_sensed", {14'd0, STATE}, 16'd2);
    WD = wd; ZID = zid; WEX = 1; WEY = 1;
    cyc();
    cyc();
    WEX = 0; WEY = 0;
    cyc();
    ZID = 0;
  endtask

  task automatic peek(input int eb, input int xt, input int xb, input int yb, input logic [15:0] exp);
    sel(eb, xt, xb, yb);
    rw_cycle(exp, 1'b0, exp);
  endtask

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_sa", SA, 16'h0000);
    chk("reset_sav", {15'd0, SAV}, 16'd0);
    chk("reset_err", {15'd0, ERR}, 16'd0);
    chk("reset_state", {14'd0, STATE}, 16'd0);

    // Basic rewrite keeps the word.
    preload(3, 2, 5, 1, 16'h5A5A);
    sel(3, 2, 5, 1);
    rw_cycle(16'h5A5A, 1'b0, 16'h5A5A);
    chk("rewrite_err", {15'd0, ERR}, 16'd0);
    chk("rewrite_state_idle", {14'd0, STATE}, 16'd0);
    chk("rewrite_sav_clear", {15'd0, SAV}, 16'd0);
    peek(3, 2, 5, 1, 16'h5A5A);

    // Read ended by an inhibited write leaves the cell cleared.
    sel(3, 2, 5, 1);
    rw_cycle(16'h5A5A, 1'b1, 16'hFFFF);
    peek(3, 2, 5, 1, 16'h0000);

    // Modified write replaces the word because the read cleared it.
    preload(1, 0, 7, 3, 16'h00FF);
    sel(1, 0, 7, 3);
    rw_cycle(16'h00FF, 1'b0, 16'h1234);
    chk("modify_err", {15'd0, ERR}, 16'd0);
    peek(1, 0, 7, 3, 16'h1234);

    // Write without read ORs in and flags a protocol error.
    preload(5, 4, 4, 0, 16'h00F0);
    sel(5, 4, 4, 0);
    write_no_read(16'h0F00);
    chk("wnr_err", {15'd0, ERR}, 16'd1);
    chk("wnr_state", {14'd0, STATE}, 16'd0);
    do_reset();
    peek(5, 4, 4, 0, 16'h0FF0);

    // Non-one-hot XB: no access, ERR set, stays IDLE.
    preload(0, 0, 1, 0, 16'h1111);
    preload(0, 0, 0, 0, 16'h2222);
    sel(0, 0, 0, 0);
    XB = 8'b0000_0011;
    REX = 1; REY = 1;
    cyc();
    REX = 0; REY = 0;
    chk("badsel_err", {15'd0, ERR}, 16'd1);
    chk("badsel_state", {14'd0, STATE}, 16'd0);
    cyc();
    chk("badsel_state_hold", {14'd0, STATE}, 16'd0);
    do_reset();
    peek(0, 0, 1, 0, 16'h1111);
    peek(0, 0, 0, 0, 16'h2222);

    // Read dropped without SBE loses the word.
    preload(2, 3, 3, 2, 16'h0042);
    sel(2, 3, 3, 2);
    REX = 1; REY = 1;
    cyc();
    REX = 0; REY = 0;
    cyc();
    chk("lost_err", {15'd0, ERR}, 16'd1);
    chk("lost_state", {14'd0, STATE}, 16'd2);
    chk("lost_sav", {15'd0, SAV}, 16'd0);
    do_reset();
    peek(2, 3, 3, 2, 16'h0000);

    // Reset in SENSED abandons the cycle; the read-cleared word stays zero.
    preload(7, 7, 7, 3, 16'hBEEF);
    preload(7, 7, 6, 3, 16'hCAFE);
    sel(7, 7, 7, 3);
    REX = 1; REY = 1;
    cyc();
    REX = 0; REY = 0; SBE = 1;
    exp_q.push_back(16'hBEEF);
    cyc();
    SBE = 0;
    chk("rstmid_state_sensed", {14'd0, STATE}, 16'd2);
    do_reset();
    chk("rstmid_sa", SA, 16'h0000);
    chk("rstmid_sav", {15'd0, SAV}, 16'd0);
    chk("rstmid_state", {14'd0, STATE}, 16'd0);
    chk("rstmid_err", {15'd0, ERR}, 16'd0);
    peek(7, 7, 7, 3, 16'h0000);
    peek(7, 7, 6, 3, 16'hCAFE);

    cyc();
    cyc();
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
